// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD clock controller.
//   sd_state_e   - controller FSM states
//   INIT_CLK_CNT - SD clock rising edges in the card init train
//   RESET_DIV    - divider value after reset (slow identification clock)
package sd_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RUN   = 3'd1,
    ST_INIT  = 3'd2,
    ST_STOP1 = 3'd3,
    ST_STOP2 = 3'd4
  } sd_state_e;

  localparam int         INIT_CLK_CNT = 80;
  localparam logic [7:0] RESET_DIV    = 8'd125;

endpackage

// File: rtl/sd_clk_ctrl_if.sv
// sd_clk_ctrl_if: register, bus-status and divider-control signals of the
// SD clock controller.
//   master - register block / bus / divider side (drives requests & status)
//   slave  - sd_clk_ctrl (drives divider value, enable, stop, status flags)
interface sd_clk_ctrl_if;
  import sd_pkg::*;

  logic       reg_clk_en;
  logic [7:0] reg_divider;
  logic       reg_div_wr;
  logic       init_req;
  logic       sd_clk_rise;
  logic       cmd_busy;
  logic       data_active;
  logic       data_dir;
  logic       rx_fifo_full;
  logic       tx_fifo_empty;
  logic [7:0] clk_divider;
  logic       sd_clk_enable;
  logic       hw_stop_clk;
  logic       init_done;
  logic       div_busy;

  modport master (
    output reg_clk_en, reg_divider, reg_div_wr, init_req, sd_clk_rise,
           cmd_busy, data_active, data_dir, rx_fifo_full, tx_fifo_empty,
    input  clk_divider, sd_clk_enable, hw_stop_clk, init_done, div_busy
  );

  modport slave (
    input  reg_clk_en, reg_divider, reg_div_wr, init_req, sd_clk_rise,
           cmd_busy, data_active, data_dir, rx_fifo_full, tx_fifo_empty,
    output clk_divider, sd_clk_enable, hw_stop_clk, init_done, div_busy
  );
endinterface

// File: rtl/sd_clk_ctrl.sv
// sd_clk_ctrl: SD card clock controller. Gates the SD clock, runs the
// 80-clock card init train, and swaps divider values glitch-free by parking
// the clock low for two hclk cycles around the change.
// Ports:
//   hclk   - system clock, posedge
//   hrst_n - asynchronous active-low reset
//   sd_if  - sd_clk_ctrl_if.slave: register requests, bus status in;
//            clk_divider, sd_clk_enable, hw_stop_clk, init_done, div_busy out
// All outputs come straight from flops.
module sd_clk_ctrl
  import sd_pkg::*;
(
  input  logic          hclk,
  input  logic          hrst_n,
  sd_clk_ctrl_if.slave  sd_if
);

  sd_state_e  state_q;
  logic [7:0] clk_div_q;
  logic [7:0] pend_q;
  logic       en_q;
  logic       hw_stop_q;
  logic       init_done_q;
  logic       div_busy_q;
  logic       applied_q;   // OFF-state divider already loaded, busy clears next
  logic [6:0] cnt_q;
  logic       stop_cond;

  // Clock must stall when the FIFO on the active data path cannot move.
  assign stop_cond = sd_if.data_active &
                     (( sd_if.data_dir & sd_if.rx_fifo_full) |
                      (~sd_if.data_dir & sd_if.tx_fifo_empty));

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q     <= ST_OFF;
      clk_div_q   <= RESET_DIV;
      pend_q      <= RESET_DIV;
      en_q        <= 1'b0;
      hw_stop_q   <= 1'b0;
      init_done_q <= 1'b0;
      div_busy_q  <= 1'b0;
      applied_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hw_stop_q <= (state_q == ST_RUN) & stop_cond;
      applied_q <= 1'b0;
      // Outputs are set from the state being entered so they line up with it.
      case (state_q)
        ST_OFF: begin
          // Clock already off: load divider, then drop busy one cycle later.
          if (div_busy_q) begin
            if (!applied_q) begin
              clk_div_q <= pend_q;
              applied_q <= 1'b1;
            end else begin
              div_busy_q <= 1'b0;
            end
          end
          if (sd_if.reg_clk_en) begin
            state_q <= ST_RUN;
            en_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!sd_if.reg_clk_en) begin
            // Disable beats a pending divider change; OFF applies it.
            if (!sd_if.cmd_busy) begin
              state_q <= ST_OFF;
              en_q    <= 1'b0;
            end
          end else if (sd_if.init_req) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
          end else if (div_busy_q && !sd_if.cmd_busy && !sd_if.data_active) begin
            state_q   <= ST_STOP1;
            en_q      <= 1'b0;
            clk_div_q <= pend_q;
          end
        end
        ST_INIT: begin
          if (!sd_if.reg_clk_en) begin
            state_q <= ST_OFF;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end else if (sd_if.sd_clk_rise) begin
            if (cnt_q == 7'(INIT_CLK_CNT - 1)) begin
              state_q     <= ST_RUN;
              init_done_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end
        end
        ST_STOP1: begin
          state_q    <= ST_STOP2;
          div_busy_q <= 1'b0;
        end
        ST_STOP2: begin
          state_q <= ST_RUN;
          en_q    <= 1'b1;
        end
        default: begin
          state_q <= ST_OFF;
          en_q    <= 1'b0;
        end
      endcase
      // A new write always wins over any busy clear above (latest wins).
      if (sd_if.reg_div_wr) begin
        pend_q     <= sd_if.reg_divider;
        div_busy_q <= 1'b1;
        applied_q  <= 1'b0;
      end
    end
  end

  assign sd_if.clk_divider   = clk_div_q;
  assign sd_if.sd_clk_enable = en_q;
  assign sd_if.hw_stop_clk   = hw_stop_q;
  assign sd_if.init_done     = init_done_q;
  assign sd_if.div_busy      = div_busy_q;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// tb_sd_clk_ctrl: self-checking bench for sd_clk_ctrl. Scenarios with
// randomized parameters; expectations come from the controller's rules
// (expected divider tracked in cur_div, stop window as a fixed 2-cycle gap,
// hw_stop as the one-cycle-delayed FIFO stall condition).
module tb_sd_clk_ctrl;
  logic hclk = 1'b0;
  logic hrst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] cur_div;

  sd_clk_ctrl_if sd_if ();

  sd_clk_ctrl u_dut (
    .hclk   (hclk),
    .hrst_n (hrst_n),
    .sd_if  (sd_if)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic wr_div(input logic [7:0] v);
    sd_if.reg_divider = v;
    sd_if.reg_div_wr  = 1'b1;
    tick();
    sd_if.reg_div_wr  = 1'b0;
  endtask

  // Wait for the clock to drop, then expect exactly two low cycles with the
  // new divider in place and busy cleared before the clock returns.
  task automatic watch_stop(input string tag, input logic [7:0] exp_div, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!sd_if.sd_clk_enable) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_div"}, sd_if.clk_divider, exp_div);
    chk({tag, "_busy1"}, sd_if.div_busy, 1);
    tick();
    chk({tag, "_en_lo2"}, sd_if.sd_clk_enable, 0);
    chk({tag, "_busy0"}, sd_if.div_busy, 0);
    tick();
    chk({tag, "_en_back"}, sd_if.sd_clk_enable, 1);
    cur_div = exp_div;
  endtask

  task automatic no_fall(input string tag, input int n);
    int falls = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!sd_if.sd_clk_enable) falls++;
    end
    chk(tag, falls, 0);
  endtask

  task automatic rise();
    sd_if.sd_clk_rise = 1'b1;
    tick();
    sd_if.sd_clk_rise = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    logic       exp_hw;
    hrst_n = 1'b0;
    sd_if.reg_clk_en = 0; sd_if.reg_divider = 0; sd_if.reg_div_wr = 0;
    sd_if.init_req = 0; sd_if.sd_clk_rise = 0; sd_if.cmd_busy = 0;
    sd_if.data_active = 0; sd_if.data_dir = 0; sd_if.rx_fifo_full = 0;
    sd_if.tx_fifo_empty = 0;
    cur_div = 8'd125;
    tick(); tick();
    chk("rst_en", sd_if.sd_clk_enable, 0);
    chk("rst_div", sd_if.clk_divider, 125);
    chk("rst_busy", sd_if.div_busy, 0);
    chk("rst_done", sd_if.init_done, 0);
    chk("rst_hw", sd_if.hw_stop_clk, 0);
    hrst_n = 1'b1;
    tick();
    chk("off_en", sd_if.sd_clk_enable, 0);

    // Enable -> clock on one cycle later at the reset divider.
    sd_if.reg_clk_en = 1'b1;
    tick();
    chk("on_en", sd_if.sd_clk_enable, 1);
    chk("on_div", sd_if.clk_divider, 125);

    // Init train aborted after 40 edges.
    sd_if.init_req = 1'b1; tick(); sd_if.init_req = 1'b0;
    for (int p = 0; p < 40; p++) begin
      rise();
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("abort_en_before", sd_if.sd_clk_enable, 1);
    sd_if.reg_clk_en = 1'b0;
    tick();
    chk("abort_en", sd_if.sd_clk_enable, 0);
    chk("abort_done", sd_if.init_done, 0);
    sd_if.reg_clk_en = 1'b1;
    tick();
    chk("reen_en", sd_if.sd_clk_enable, 1);

    // Full init train from a cleared counter; divider write deferred.
    w = 8'($urandom_range(0, 255));
    sd_if.init_req = 1'b1; tick(); sd_if.init_req = 1'b0;
    for (int p = 1; p <= 80; p++) begin
      rise();
      if (p == 79) chk("init_done_79", sd_if.init_done, 0);
      if (p == 80) begin
        chk("init_done_80", sd_if.init_done, 1);
        chk("init_en_80", sd_if.sd_clk_enable, 1);
        chk("init_div_held", sd_if.clk_divider, cur_div);
      end
      if (p == 20) begin
        wr_div(w);
        chk("init_wr_busy", sd_if.div_busy, 1);
      end
      if (p < 80) repeat ($urandom_range(0, 3)) tick();
    end
    watch_stop("init_defer", w, 3);

    // hw_stop: 3-cycle FIFO pulse on each direction, high 3 cycles one later.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        sd_if.data_active   = 1'b1;
        sd_if.data_dir      = d[0];
        sd_if.rx_fifo_full  = d[0]  && i >= 2 && i < 5;
        sd_if.tx_fifo_empty = !d[0] && i >= 2 && i < 5;
        tick();
        chk(d ? "hw_rx_pulse" : "hw_tx_pulse", sd_if.hw_stop_clk, (i >= 2 && i < 5));
      end
    end
    // Random bus status stream.
    for (int i = 0; i < 60; i++) begin
      sd_if.data_active   = 1'($urandom);
      sd_if.data_dir      = 1'($urandom);
      sd_if.rx_fifo_full  = 1'($urandom);
      sd_if.tx_fifo_empty = 1'($urandom);
      exp_hw = sd_if.data_active &&
               (sd_if.data_dir ? sd_if.rx_fifo_full : sd_if.tx_fifo_empty);
      tick();
      chk("hw_rand", sd_if.hw_stop_clk, exp_hw);
    end
    sd_if.data_dir = 0; sd_if.rx_fifo_full = 0; sd_if.tx_fifo_empty = 0;

    // Divider change held off while data is active.
    sd_if.data_active = 1'b1;
    wr_div(8'd2);
    chk("da_busy", sd_if.div_busy, 1);
    for (int i = 0, n = $urandom_range(3, 10); i < n; i++) begin
      tick();
      if (sd_if.sd_clk_enable !== 1'b1 || sd_if.clk_divider !== cur_div) begin
        chk("da_hold_en", sd_if.sd_clk_enable, 1);
        chk("da_hold_div", sd_if.clk_divider, cur_div);
      end
    end
    chk("da_hold_final", sd_if.clk_divider, cur_div);
    sd_if.data_active = 1'b0;
    watch_stop("da", 8'd2, 3);

    // Back-to-back writes under cmd_busy: latest wins, single stop.
    sd_if.cmd_busy = 1'b1;
    wr_div(8'd4);
    wr_div(8'd9);
    no_fall("cmd_hold", 5);
    chk("cmd_hold_div", sd_if.clk_divider, cur_div);
    sd_if.cmd_busy = 1'b0;
    watch_stop("b2b", 8'd9, 3);
    no_fall("b2b_single", 20);

    // Divider 0 is a legal value.
    wr_div(8'd0);
    watch_stop("div0", 8'd0, 3);

    // Write with simultaneous disable: goes OFF, applied there.
    w = 8'($urandom_range(1, 255));
    sd_if.reg_divider = w; sd_if.reg_div_wr = 1'b1; sd_if.reg_clk_en = 1'b0;
    tick();
    sd_if.reg_div_wr = 1'b0;
    chk("dis_wr_en", sd_if.sd_clk_enable, 0);
    chk("dis_wr_busy", sd_if.div_busy, 1);
    chk("dis_wr_div_old", sd_if.clk_divider, cur_div);
    tick();
    chk("off_apply_div", sd_if.clk_divider, w);
    chk("off_apply_busy1", sd_if.div_busy, 1);
    tick();
    chk("off_apply_busy0", sd_if.div_busy, 0);
    cur_div = w;

    // hw_stop forced low outside RUN.
    sd_if.data_active = 1'b1; sd_if.data_dir = 1'b1; sd_if.rx_fifo_full = 1'b1;
    tick(); tick();
    chk("hw_off", sd_if.hw_stop_clk, 0);
    sd_if.data_active = 1'b0; sd_if.rx_fifo_full = 1'b0;
    sd_if.reg_clk_en = 1'b1;
    tick();
    chk("reen2_en", sd_if.sd_clk_enable, 1);
    no_fall("reen2_stable", 5);
    chk("done_sticky", sd_if.init_done, 1);

    // Reset during STOP1 restores everything at once.
    wr_div(8'($urandom_range(0, 255)));
    tick();
    chk("stop1_en", sd_if.sd_clk_enable, 0);
    hrst_n = 1'b0;
    #1;
    chk("rst_stop_en", sd_if.sd_clk_enable, 0);
    chk("rst_stop_div", sd_if.clk_divider, 125);
    chk("rst_stop_busy", sd_if.div_busy, 0);
    chk("rst_stop_done", sd_if.init_done, 0);
    chk("rst_stop_hw", sd_if.hw_stop_clk, 0);
    hrst_n = 1'b1;
    tick();
    chk("post_rst_en", sd_if.sd_clk_enable, 1);
    no_fall("post_rst_nostop", 10);
    chk("post_rst_div", sd_if.clk_divider, 125);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
